bus_responder: RTL and testbench
================================

# bus_responder

Target-side endpoint of the CPU's rdy/ack byte bus. It watches `rdy`, `bus_ctrl` and `bus_wr` from the bus controller and assembles the 16-bit address from the ADDR0 and ADDR1 phases. Each DATA phase is routed to a local memory port or to a character channel, and `ack` completes the handshake. It sits at the far end of the hardware bus, in front of program/data memory and the console.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `rdy` in 1: initiator phase request.
- `bus_ctrl` in 2: phase type: 0 = ADDR0, 1 = ADDR1, 3 = DATA, 2 = reserved.
- `bus_wr` in 1: DATA phase direction: 1 = write to target, 0 = read from target.
- `bus_in` in 8: byte driven by the initiator.
- `ack` out 1: phase complete.
- `bus_out` out 8: read data toward the initiator.
- `bus_oe` out 1: `bus_out` valid/drive enable.
- `mem_req` out 1: memory request, held until `mem_ack`.
- `mem_we` out 1: memory write.
- `mem_addr` out 16: memory address.
- `mem_wdata` out 8: memory write data.
- `mem_ack` in 1: memory done; `mem_rdata` is valid on reads.
- `mem_rdata` in 8: memory read data.
- `chr_out_valid` out 1, `chr_out_data` out 8, `chr_out_ready` in 1: console output stream.
- `chr_in_valid` in 1, `chr_in_data` in 8, `chr_in_ready` out 1: console input stream.

## Operation
- `rdy_s`: `rdy`, `bus_ctrl` and `bus_wr` as seen by the FSM (see Configuration).
- Address flags `a0v`/`a1v` and address register `addr[15:0]`:
  - ADDR0 sets `addr[7:0]` and `a0v`; ADDR1 sets `addr[15:8]` and `a1v`.
  - A repeated phase overwrites the byte.
  - Any DATA phase clears both flags at completion.
- FSM states: IDLE, MEM, CHR, ACK, HOLD.
- IDLE, when `rdy_s` is high:
  - ADDR0/ADDR1: capture `bus_in`, go to ACK.
  - Reserved code 2: go to ACK with no side effects.
  - DATA with `a0v & a1v`: go to MEM.
  - DATA otherwise: go to CHR.
- MEM:
  - Drives `mem_req=1`, `mem_addr=addr`, `mem_we=bus_wr`, `mem_wdata=bus_in`.
  - On `mem_ack`: drop `mem_req`; on a read, register `mem_rdata` into `bus_out`; go to ACK.
- CHR, write: `chr_out_valid=1`, `chr_out_data=bus_in`; on `chr_out_ready`, go to ACK.
- CHR, read: `chr_in_ready=1`; on `chr_in_valid`, register `chr_in_data` into `bus_out`; go to ACK.
- ACK:
  - `ack=1`.
  - `bus_oe=1` while the phase is a DATA read.
  - On `rdy_s` low: `ack=0`, `bus_oe=0`, go to HOLD.
- HOLD:
  - `ack` stays low for exactly 2 cycles, then IDLE.
  - Reason: the initiator edge-detects `ack` through a 2-flop delay, so every rise must follow at least 2 low cycles.
  - `rdy` may rise during HOLD; IDLE acts on its level.
- `bus_out` holds its last value outside reads; only `bus_oe` qualifies it.
- Reserved `bus_ctrl`=2 is acked with no side effects.

## Timing
- Reset values: `ack`, `bus_oe`, `mem_req`, `mem_we`, `chr_out_valid`, `chr_in_ready` = 0; `bus_out`, `mem_addr`, `mem_wdata`, `chr_out_data` = 0; FSM in IDLE; `a0v`/`a1v` = 0.
- Address phase: `ack` rises 1 clk after the edge at which IDLE sees `rdy_s`.
- DATA phase:
  - `mem_req`/`chr_*_valid|ready` rise 1 clk after IDLE sees `rdy_s`.
  - `ack` rises 1 clk after the `mem_ack` or stream handshake edge.
  - Read data is in `bus_out` in the same cycle `ack` rises and is held until `rdy_s` falls.
- Minimum `ack` low time between phases is 2 clk.
- `mem_ack` or handshake in the first request cycle is legal (zero wait).
- Async reset mid-phase:
  - Outputs drop immediately; the flags clear.
  - A pending memory or char transfer is abandoned, with no retry.

## Configuration
- `BUS_RESP_SYNC_EN` defined:
  - `rdy`, `bus_ctrl` and `bus_wr` pass through 2-flop synchronizers, for an initiator on an unrelated clock.
  - All IDLE/ACK reactions are 2 clk later than listed in Timing.
  - `bus_in` is sampled only after synchronized `rdy`.
- Not defined: inputs are used directly (same-clock initiator), with the latencies exactly as listed.

## Test plan
- ADDR0 0x34, then ADDR1 0x12, then DATA write 0x5A → `mem_req` with `mem_we=1`, `mem_addr=0x1234`, `mem_wdata=0x5A`; `ack` after `mem_ack`; flags cleared.
- ADDR0 0xFF, ADDR1 0x00, DATA read, `mem_rdata`=0xC3 with 3-cycle `mem_ack` delay → `bus_out`=0xC3 with `bus_oe=1` from `ack` rise until `rdy` falls.
- DATA write 0x41 with no address phases, `chr_out_ready` held low 5 clk → `chr_out_valid` held with data 0x41; `ack` 1 clk after ready; `mem_req` never asserted.
- ADDR1 only, then DATA read with `chr_in_data`=0x0A → routed to the char channel (`a0v` missing); `bus_out`=0x0A.
- Back-to-back phases with `rdy` low for 1 clk → `ack` low for exactly 2 clk between phases; both phases complete.
- `reset_n` asserted while in MEM with `mem_req` high → all outputs 0 the same cycle; next DATA with no address goes to CHR.

Source files
------------

// File: rtl/bus_responder_if.sv
// Signal bundle for bus_responder: initiator byte bus, local memory port and console streams.
// slave = the responder side, master = initiator/memory/console side.
interface bus_responder_if;
    logic        rdy;
    logic [1:0]  bus_ctrl;
    logic        bus_wr;
    logic [7:0]  bus_in;
    logic        ack;
    logic [7:0]  bus_out;
    logic        bus_oe;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        chr_out_valid;
    logic [7:0]  chr_out_data;
    logic        chr_out_ready;
    logic        chr_in_valid;
    logic [7:0]  chr_in_data;
    logic        chr_in_ready;

    modport slave (
        input  rdy, bus_ctrl, bus_wr, bus_in, mem_ack, mem_rdata,
               chr_out_ready, chr_in_valid, chr_in_data,
        output ack, bus_out, bus_oe, mem_req, mem_we, mem_addr, mem_wdata,
               chr_out_valid, chr_out_data, chr_in_ready
    );

    modport master (
        output rdy, bus_ctrl, bus_wr, bus_in, mem_ack, mem_rdata,
               chr_out_ready, chr_in_valid, chr_in_data,
        input  ack, bus_out, bus_oe, mem_req, mem_we, mem_addr, mem_wdata,
               chr_out_valid, chr_out_data, chr_in_ready
    );
endinterface

// File: rtl/bus_responder.sv
// Target endpoint of the rdy/ack byte bus: assembles a 16-bit address, routes DATA phases to memory or console.
// Define BUS_RESP_SYNC_EN to pass rdy/bus_ctrl/bus_wr through 2-flop synchronizers (initiator on another clock).
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for rdy_s; decodes the phase type
// MEM    | memory request outstanding until mem_ack
// CHR    | console stream transfer until the stream handshake
// ACK    | ack high; waits for the initiator to drop rdy_s
// HOLD   | ack low guard cycle before IDLE
module bus_responder (
    input  logic           clk,
    input  logic           reset_n,
    bus_responder_if.slave bif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MEM  = 3'd1,
        S_CHR  = 3'd2,
        S_ACK  = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    localparam logic [1:0] CTRL_ADDR0 = 2'd0;
    localparam logic [1:0] CTRL_ADDR1 = 2'd1;
    localparam logic [1:0] CTRL_DATA  = 2'd3;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        w_rdy_s;
    logic [1:0]  w_ctrl_s;
    logic        w_wr_s;

    logic [15:0] r_addr;
    logic        r_a0v;
    logic        r_a1v;
    logic        r_wr;
    logic        r_data;
    logic [15:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic [7:0]  r_chr_out_data;
    logic [7:0]  r_bus_out;

    logic        w_stream_done;

`ifdef BUS_RESP_SYNC_EN
    logic [1:0]  r_rdy_sync;
    logic [1:0]  r_ctrl_sync0;
    logic [1:0]  r_ctrl_sync1;
    logic [1:0]  r_wr_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdy_sync   <= 2'b00;
            r_ctrl_sync0 <= 2'b00;
            r_ctrl_sync1 <= 2'b00;
            r_wr_sync    <= 2'b00;
        end else begin
            r_rdy_sync   <= {r_rdy_sync[0], bif.rdy};
            r_ctrl_sync0 <= bif.bus_ctrl;
            r_ctrl_sync1 <= r_ctrl_sync0;
            r_wr_sync    <= {r_wr_sync[0], bif.bus_wr};
        end
    end

    assign w_rdy_s  = r_rdy_sync[1];
    assign w_ctrl_s = r_ctrl_sync1;
    assign w_wr_s   = r_wr_sync[1];
`else
    assign w_rdy_s  = bif.rdy;
    assign w_ctrl_s = bif.bus_ctrl;
    assign w_wr_s   = bif.bus_wr;
`endif

    assign w_stream_done = r_wr ? bif.chr_out_ready : bif.chr_in_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A single HOLD cycle plus the IDLE decision cycle keep ack low for 2 clk minimum.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_rdy_s) begin
                    if (w_ctrl_s == CTRL_DATA) begin
                        w_state_nxt = (r_a0v && r_a1v) ? S_MEM : S_CHR;
                    end else begin
                        w_state_nxt = S_ACK;
                    end
                end
            end
            S_MEM: begin
                if (bif.mem_ack) begin
                    w_state_nxt = S_ACK;
                end
            end
            S_CHR: begin
                if (w_stream_done) begin
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                if (!w_rdy_s) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr         <= 16'h0000;
            r_a0v          <= 1'b0;
            r_a1v          <= 1'b0;
            r_wr           <= 1'b0;
            r_data         <= 1'b0;
            r_mem_addr     <= 16'h0000;
            r_mem_wdata    <= 8'h00;
            r_chr_out_data <= 8'h00;
            r_bus_out      <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rdy_s) begin
                        r_wr   <= w_wr_s;
                        r_data <= (w_ctrl_s == CTRL_DATA);
                        case (w_ctrl_s)
                            CTRL_ADDR0: begin
                                r_addr[7:0] <= bif.bus_in;
                                r_a0v       <= 1'b1;
                            end
                            CTRL_ADDR1: begin
                                r_addr[15:8] <= bif.bus_in;
                                r_a1v        <= 1'b1;
                            end
                            CTRL_DATA: begin
                                if (r_a0v && r_a1v) begin
                                    r_mem_addr <= r_addr;
                                    if (w_wr_s) begin
                                        r_mem_wdata <= bif.bus_in;
                                    end
                                end else if (w_wr_s) begin
                                    r_chr_out_data <= bif.bus_in;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                S_MEM: begin
                    if (bif.mem_ack && !r_wr) begin
                        r_bus_out <= bif.mem_rdata;
                    end
                end
                S_CHR: begin
                    if (bif.chr_in_valid && !r_wr) begin
                        r_bus_out <= bif.chr_in_data;
                    end
                end
                S_ACK: begin
                    if (!w_rdy_s && r_data) begin
                        r_a0v <= 1'b0;
                        r_a1v <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bif.ack           = (r_state == S_ACK);
    assign bif.bus_oe        = (r_state == S_ACK) && r_data && !r_wr;
    assign bif.bus_out       = r_bus_out;
    assign bif.mem_req       = (r_state == S_MEM);
    assign bif.mem_we        = (r_state == S_MEM) && r_wr;
    assign bif.mem_addr      = r_mem_addr;
    assign bif.mem_wdata     = r_mem_wdata;
    assign bif.chr_out_valid = (r_state == S_CHR) && r_wr;
    assign bif.chr_out_data  = r_chr_out_data;
    assign bif.chr_in_ready  = (r_state == S_CHR) && !r_wr;

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: directed phases from the test plan plus random phases against a transaction-level model.
module tb_bus_responder;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    bus_responder_if bif();

    bus_responder u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bif     (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          route;      // bit0 mem_req, bit1 chr_out_valid, bit2 chr_in_ready seen
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic [7:0]  bout;
        logic        oe;
        int          ack_cyc;    // negedge index where ack first seen, -1 if never
        bit          hold_ok;
        int          req_cycles;
    } res_t;

    // transaction-level model state
    logic        m_a0v, m_a1v;
    logic [15:0] m_addr;
    logic [7:0]  m_bout;
    int          m_gap;

    task automatic clear_res(output res_t r);
        r.route = 0; r.addr = '0; r.we = 1'b0; r.wdata = '0; r.bout = '0;
        r.oe = 1'b0; r.ack_cyc = -1; r.hold_ok = 1'b1; r.req_cycles = 0;
    endtask

    task automatic model_reset();
        m_a0v = 1'b0; m_a1v = 1'b0; m_addr = '0; m_bout = '0; m_gap = 2;
    endtask

    // ack must stay low 2 clk in total and IDLE reacts 1 clk after seeing rdy
    task automatic model_phase(input logic [1:0] ctrl, input logic wr, input logic [7:0] din,
                               input int dly, input logic [7:0] rd, input int gap, output res_t e);
        int base;
        clear_res(e);
        base = (m_gap >= 2) ? 0 : 2 - m_gap;
        e.ack_cyc = base;
        e.bout = m_bout;
        case (ctrl)
            2'd0: begin m_addr[7:0] = din; m_a0v = 1'b1; end
            2'd1: begin m_addr[15:8] = din; m_a1v = 1'b1; end
            2'd3: begin
                e.route = (m_a0v && m_a1v) ? 1 : (wr ? 2 : 4);
                e.addr = m_addr;
                e.we = wr;
                e.wdata = din;
                e.req_cycles = dly + 1;
                e.ack_cyc = base + dly + 1;
                if (!wr) m_bout = rd;
                e.bout = m_bout;
                e.oe = !wr;
                m_a0v = 1'b0;
                m_a1v = 1'b0;
            end
            default: ;
        endcase
        m_gap = gap;
    endtask

    // Runs one phase from a negedge: rdy high, serve requests after dly request cycles,
    // keep rdy up for hold cycles after ack, then rdy low for gap cycles.
    task automatic do_phase(input logic [1:0] ctrl, input logic wr, input logic [7:0] din,
                            input int dly, input logic [7:0] rd, input int hold, input int gap,
                            output res_t r);
        int reqn;
        clear_res(r);
        reqn = 0;
        bif.rdy = 1'b1; bif.bus_ctrl = ctrl; bif.bus_wr = wr; bif.bus_in = din;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (bif.ack === 1'b1) begin
                r.ack_cyc = c;
                break;
            end
            bif.mem_ack = 1'b0; bif.chr_out_ready = 1'b0; bif.chr_in_valid = 1'b0;
            bif.mem_rdata = 8'($urandom); bif.chr_in_data = 8'($urandom);
            if (bif.mem_req === 1'b1) begin
                r.route |= 1; r.addr = bif.mem_addr; r.we = bif.mem_we; r.wdata = bif.mem_wdata;
            end
            if (bif.chr_out_valid === 1'b1) begin
                r.route |= 2; r.wdata = bif.chr_out_data;
            end
            if (bif.chr_in_ready === 1'b1) r.route |= 4;
            if (bif.mem_req === 1'b1 || bif.chr_out_valid === 1'b1 || bif.chr_in_ready === 1'b1) begin
                if (reqn == dly) begin
                    if (bif.mem_req === 1'b1) begin bif.mem_ack = 1'b1; bif.mem_rdata = rd; end
                    if (bif.chr_out_valid === 1'b1) bif.chr_out_ready = 1'b1;
                    if (bif.chr_in_ready === 1'b1) begin bif.chr_in_valid = 1'b1; bif.chr_in_data = rd; end
                end
                reqn++;
            end
        end
        r.req_cycles = reqn;
        bif.mem_ack = 1'b0; bif.chr_out_ready = 1'b0; bif.chr_in_valid = 1'b0;
        bif.mem_rdata = 8'($urandom); bif.chr_in_data = 8'($urandom);
        r.bout = bif.bus_out;
        r.oe = bif.bus_oe;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (bif.ack !== 1'b1 || bif.bus_out !== r.bout || bif.bus_oe !== r.oe) r.hold_ok = 1'b0;
        end
        bif.rdy = 1'b0; bif.bus_ctrl = 2'($urandom); bif.bus_wr = 1'($urandom); bif.bus_in = 8'($urandom);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            if (g == 0 && (bif.ack !== 1'b0 || bif.bus_oe !== 1'b0)) r.hold_ok = 1'b0;
        end
    endtask

    task automatic apply_reset();
        bif.rdy = 1'b0; bif.bus_ctrl = 2'd0; bif.bus_wr = 1'b0; bif.bus_in = 8'h00;
        bif.mem_ack = 1'b0; bif.mem_rdata = 8'h00;
        bif.chr_out_ready = 1'b0; bif.chr_in_valid = 1'b0; bif.chr_in_data = 8'h00;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({bif.ack, bif.bus_oe, bif.mem_req, bif.mem_we, bif.chr_out_valid, bif.chr_in_ready} !== 6'b0) begin
            bad++; $display("FAIL rst_ctrl: got %b want 000000",
                {bif.ack, bif.bus_oe, bif.mem_req, bif.mem_we, bif.chr_out_valid, bif.chr_in_ready});
        end
        total++;
        if (bif.bus_out !== 8'h00) begin bad++; $display("FAIL rst_bus_out: got %h want 00", bif.bus_out); end
        total++;
        if (bif.mem_addr !== 16'h0000) begin bad++; $display("FAIL rst_mem_addr: got %h want 0000", bif.mem_addr); end
        total++;
        if (bif.mem_wdata !== 8'h00) begin bad++; $display("FAIL rst_mem_wdata: got %h want 00", bif.mem_wdata); end
        total++;
        if (bif.chr_out_data !== 8'h00) begin bad++; $display("FAIL rst_chr_out_data: got %h want 00", bif.chr_out_data); end
    endtask

    task automatic test_mem_write();
        res_t r;
        do_phase(2'd0, 1'b0, 8'h34, 0, 8'h00, 0, 3, r);
        total++;
        if (r.ack_cyc !== 0 || r.route !== 0) begin
            bad++; $display("FAIL mw_addr0: got ack_cyc=%0d route=%0d want 0/0", r.ack_cyc, r.route);
        end
        do_phase(2'd1, 1'b0, 8'h12, 0, 8'h00, 0, 3, r);
        total++;
        if (r.ack_cyc !== 0 || r.route !== 0) begin
            bad++; $display("FAIL mw_addr1: got ack_cyc=%0d route=%0d want 0/0", r.ack_cyc, r.route);
        end
        do_phase(2'd3, 1'b1, 8'h5A, 0, 8'h00, 1, 3, r);
        total++;
        if (r.route !== 1) begin bad++; $display("FAIL mw_route: got %0d want 1", r.route); end
        total++;
        if (r.addr !== 16'h1234) begin bad++; $display("FAIL mw_addr: got %h want 1234", r.addr); end
        total++;
        if (r.we !== 1'b1 || r.wdata !== 8'h5A) begin
            bad++; $display("FAIL mw_data: got we=%b wdata=%h want 1/5a", r.we, r.wdata);
        end
        total++;
        if (r.ack_cyc !== 1) begin bad++; $display("FAIL mw_ack_lat: got %0d want 1", r.ack_cyc); end
        do_phase(2'd3, 1'b1, 8'h66, 0, 8'h00, 0, 3, r);
        total++;
        if (r.route !== 2) begin bad++; $display("FAIL mw_flags_clr: got route %0d want 2", r.route); end
    endtask

    task automatic test_mem_read();
        res_t r;
        do_phase(2'd0, 1'b0, 8'hFF, 0, 8'h00, 0, 3, r);
        do_phase(2'd1, 1'b0, 8'h00, 0, 8'h00, 0, 3, r);
        do_phase(2'd3, 1'b0, 8'h00, 3, 8'hC3, 3, 3, r);
        total++;
        if (r.route !== 1 || r.addr !== 16'h00FF || r.we !== 1'b0) begin
            bad++; $display("FAIL mr_req: got route=%0d addr=%h we=%b want 1/00ff/0", r.route, r.addr, r.we);
        end
        total++;
        if (r.bout !== 8'hC3 || r.oe !== 1'b1) begin
            bad++; $display("FAIL mr_data: got bus_out=%h oe=%b want c3/1", r.bout, r.oe);
        end
        total++;
        if (r.ack_cyc !== 4) begin bad++; $display("FAIL mr_ack_lat: got %0d want 4", r.ack_cyc); end
        total++;
        if (r.hold_ok !== 1'b1) begin bad++; $display("FAIL mr_hold: got %b want 1", r.hold_ok); end
    endtask

    task automatic test_chr_write();
        res_t r;
        do_phase(2'd3, 1'b1, 8'h41, 5, 8'h00, 0, 3, r);
        total++;
        if (r.route !== 2) begin bad++; $display("FAIL cw_route: got %0d want 2", r.route); end
        total++;
        if (r.wdata !== 8'h41 || r.req_cycles !== 6) begin
            bad++; $display("FAIL cw_valid: got data=%h cycles=%0d want 41/6", r.wdata, r.req_cycles);
        end
        total++;
        if (r.ack_cyc !== 6) begin bad++; $display("FAIL cw_ack_lat: got %0d want 6", r.ack_cyc); end
    endtask

    task automatic test_chr_read();
        res_t r;
        do_phase(2'd1, 1'b0, 8'h20, 0, 8'h00, 0, 3, r);
        do_phase(2'd3, 1'b0, 8'h00, 1, 8'h0A, 2, 3, r);
        total++;
        if (r.route !== 4) begin bad++; $display("FAIL cr_route: got %0d want 4", r.route); end
        total++;
        if (r.bout !== 8'h0A || r.oe !== 1'b1 || r.hold_ok !== 1'b1) begin
            bad++; $display("FAIL cr_data: got bus_out=%h oe=%b hold=%b want 0a/1/1", r.bout, r.oe, r.hold_ok);
        end
    endtask

    task automatic test_reserved();
        res_t r;
        do_phase(2'd0, 1'b0, 8'h11, 0, 8'h00, 0, 3, r);
        do_phase(2'd2, 1'b1, 8'h99, 0, 8'h00, 1, 3, r);
        total++;
        if (r.ack_cyc !== 0 || r.route !== 0 || r.oe !== 1'b0 || r.bout !== 8'h0A) begin
            bad++; $display("FAIL rsv_phase: got ack_cyc=%0d route=%0d oe=%b bus_out=%h want 0/0/0/0a",
                            r.ack_cyc, r.route, r.oe, r.bout);
        end
        do_phase(2'd1, 1'b0, 8'h22, 0, 8'h00, 0, 3, r);
        do_phase(2'd3, 1'b1, 8'h5C, 2, 8'h00, 0, 3, r);
        total++;
        if (r.route !== 1 || r.addr !== 16'h2211 || r.wdata !== 8'h5C) begin
            bad++; $display("FAIL rsv_no_side_effect: got route=%0d addr=%h wdata=%h want 1/2211/5c",
                            r.route, r.addr, r.wdata);
        end
    endtask

    task automatic test_back_to_back();
        res_t r;
        int low;
        do_phase(2'd0, 1'b0, 8'hA5, 0, 8'h00, 0, 1, r);
        total++;
        if (r.ack_cyc !== 0 || r.hold_ok !== 1'b1) begin
            bad++; $display("FAIL b2b_first: got ack_cyc=%0d drop=%b want 0/1", r.ack_cyc, r.hold_ok);
        end
        do_phase(2'd1, 1'b0, 8'h5A, 0, 8'h00, 0, 1, r);
        low = 1 + r.ack_cyc;
        total++;
        if (r.ack_cyc < 0 || low !== 2) begin
            bad++; $display("FAIL b2b_ack_low: got %0d cycles want 2", low);
        end
        do_phase(2'd3, 1'b1, 8'h3C, 0, 8'h00, 0, 3, r);
        total++;
        if (r.route !== 1 || r.addr !== 16'h5AA5 || r.ack_cyc !== 2) begin
            bad++; $display("FAIL b2b_data: got route=%0d addr=%h ack_cyc=%0d want 1/5aa5/2", r.route, r.addr, r.ack_cyc);
        end
    endtask

    task automatic test_reset_mid();
        res_t r;
        bit seen;
        logic [45:0] outs;
        do_phase(2'd0, 1'b0, 8'h78, 0, 8'h00, 0, 3, r);
        do_phase(2'd1, 1'b0, 8'h56, 0, 8'h00, 0, 3, r);
        bif.rdy = 1'b1; bif.bus_ctrl = 2'd3; bif.bus_wr = 1'b1; bif.bus_in = 8'h99;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bif.mem_req === 1'b1) begin seen = 1'b1; break; end
        end
        total++;
        if (seen !== 1'b1) begin bad++; $display("FAIL rm_mem_req: got %b want 1", seen); end
        #2 reset_n = 1'b0;
        #1;
        outs = {bif.ack, bif.bus_oe, bif.mem_req, bif.mem_we, bif.chr_out_valid, bif.chr_in_ready,
                bif.bus_out, bif.mem_addr, bif.mem_wdata, bif.chr_out_data};
        total++;
        if (outs !== 46'h0) begin bad++; $display("FAIL rm_outputs: got %h want 0", outs); end
        bif.rdy = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_phase(2'd3, 1'b1, 8'h77, 1, 8'h00, 0, 3, r);
        total++;
        if (r.route !== 2 || r.wdata !== 8'h77) begin
            bad++; $display("FAIL rm_after_reset: got route=%0d data=%h want 2/77", r.route, r.wdata);
        end
    endtask

    task automatic test_random();
        res_t r, e;
        logic [1:0] ctrl;
        logic wr;
        logic [7:0] din, rd;
        int dly, hold, gap;
        apply_reset();
        model_reset();
        for (int n = 0; n < 150; n++) begin
            ctrl = 2'($urandom_range(0, 3));
            wr   = 1'($urandom);
            din  = 8'($urandom);
            rd   = 8'($urandom);
            dly  = $urandom_range(0, 3);
            hold = $urandom_range(0, 2);
            gap  = $urandom_range(1, 3);
            model_phase(ctrl, wr, din, dly, rd, gap, e);
            do_phase(ctrl, wr, din, dly, rd, hold, gap, r);
            total++;
            if (r.route !== e.route) begin bad++; $display("FAIL rnd_route[%0d]: got %0d want %0d", n, r.route, e.route); end
            total++;
            if (r.ack_cyc !== e.ack_cyc) begin bad++; $display("FAIL rnd_ack_cyc[%0d]: got %0d want %0d", n, r.ack_cyc, e.ack_cyc); end
            total++;
            if (r.bout !== e.bout || r.oe !== e.oe) begin
                bad++; $display("FAIL rnd_bus_out[%0d]: got %h/%b want %h/%b", n, r.bout, r.oe, e.bout, e.oe);
            end
            total++;
            if (r.hold_ok !== 1'b1) begin bad++; $display("FAIL rnd_hold[%0d]: got %b want 1", n, r.hold_ok); end
            if (ctrl == 2'd3) begin
                total++;
                if (r.req_cycles !== e.req_cycles) begin
                    bad++; $display("FAIL rnd_req_cycles[%0d]: got %0d want %0d", n, r.req_cycles, e.req_cycles);
                end
                if (e.route == 1) begin
                    total++;
                    if (r.addr !== e.addr || r.we !== e.we) begin
                        bad++; $display("FAIL rnd_mem_addr[%0d]: got %h/%b want %h/%b", n, r.addr, r.we, e.addr, e.we);
                    end
                end
                if (wr) begin
                    total++;
                    if (r.wdata !== e.wdata) begin bad++; $display("FAIL rnd_wdata[%0d]: got %h want %h", n, r.wdata, e.wdata); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mem_write();
        test_mem_read();
        test_chr_write();
        test_chr_read();
        test_reserved();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
